// File: rtl/ir_pkg.sv
// ============================================================================
// ir_pkg : shared widths, hysteresis default and detector state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package ir_pkg;

  localparam int IR_DATA_W   = 20;
  localparam int IR_PERIOD_W = 12;
  localparam int IR_HYST     = 256;

  typedef enum logic [1:0] {
    ST_SETTLE   = 2'd0,
    ST_SEEK_MAX = 2'd1,
    ST_SEEK_MIN = 2'd2
  } ir_state_t;

endpackage

`default_nettype wire

// File: rtl/ir_period_avg.sv
// ============================================================================
// ir_period_avg : 4-beat running mean of the period, one cycle of added latency
// Revision: 1.0
// ============================================================================
`default_nettype none

module ir_period_avg
  import ir_pkg::*;
#(
  parameter int DATA_W   = IR_DATA_W,
  parameter int PERIOD_W = IR_PERIOD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_clear,
  input  logic                i_valid,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic [DATA_W-1:0]   i_amp,
  output logic                o_valid,
  output logic [PERIOD_W-1:0] o_period,
  output logic [DATA_W-1:0]   o_amp
);

  // The three previous periods; the fourth term of the mean is the incoming one.
  logic [PERIOD_W-1:0] r_hist [3];
  logic                r_primed;
  logic                r_valid;
  logic [PERIOD_W-1:0] r_period;
  logic [DATA_W-1:0]   r_amp;
  logic [PERIOD_W+1:0] w_sum;

  always_comb begin
    w_sum = {i_period, 2'b00};
    if (r_primed) begin
      w_sum = {2'b00, r_hist[0]} + {2'b00, r_hist[1]} + {2'b00, r_hist[2]} + {2'b00, i_period};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) r_hist[i] <= '0;
      r_primed <= 1'b0;
      r_valid  <= 1'b0;
      r_period <= '0;
      r_amp    <= '0;
    end else begin
      r_valid <= i_valid;
      if (i_clear) r_primed <= 1'b0;
      if (i_valid) begin
        r_hist[0] <= i_period;
        r_hist[1] <= r_primed ? r_hist[0] : i_period;
        r_hist[2] <= r_primed ? r_hist[1] : i_period;
        r_primed  <= 1'b1;
        r_period  <= w_sum[PERIOD_W+1:2];
        r_amp     <= i_amp;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_period = r_period;
  assign o_amp    = r_amp;

endmodule

`default_nettype wire

// File: rtl/ir_peak_detector.sv
// ============================================================================
// ir_peak_detector : hysteretic peak/trough tracker reporting beat period/amp.
// Build option IR_PEAK_AVG_EN: report the mean of the last 4 accepted periods.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ir_peak_detector
  import ir_pkg::*;
#(
  parameter int DATA_W     = IR_DATA_W,
  parameter int PERIOD_W   = IR_PERIOD_W,
  parameter int SETTLE     = 21,
  parameter int HYST       = IR_HYST,
  parameter int MIN_PERIOD = 20,
  parameter int MAX_PERIOD = 4000
) (
  input  logic                CLK_Filter,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic [DATA_W-1:0]   In_IR_Filtered,
  output logic                beat_valid,
  output logic [PERIOD_W-1:0] beat_period,
  output logic [DATA_W-1:0]   beat_amp,
  output logic                timeout
);

  localparam int                  SET_W      = $clog2(SETTLE + 1);
  localparam logic [SET_W-1:0]    C_SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [PERIOD_W-1:0] C_MAXP     = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] C_MINP     = PERIOD_W'(MIN_PERIOD);
  localparam logic [DATA_W:0]     C_HYST     = (DATA_W + 1)'(HYST);

  ir_state_t           r_state, w_state_nxt;
  logic [SET_W-1:0]    r_set_cnt;
  logic [DATA_W-1:0]   r_max, r_min, r_trough;
  logic [PERIOD_W-1:0] r_cnt, w_cnt_inc;
  logic                r_first, r_timeout;
  logic                r_bv;
  logic [PERIOD_W-1:0] r_bp;
  logic [DATA_W-1:0]   r_ba;
  logic                w_peak, w_trough, w_settle_done;
  logic [DATA_W:0]     w_samp_ext;

  assign w_samp_ext = {1'b0, In_IR_Filtered};
  assign w_cnt_inc  = (r_cnt == C_MAXP) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) r_state <= ST_SETTLE;
    else        r_state <= w_state_nxt;
  end

  // Compares are one bit wider than the data so sample+HYST never wraps.
  always_comb begin
    w_state_nxt   = r_state;
    w_peak        = 1'b0;
    w_trough      = 1'b0;
    w_settle_done = 1'b0;
    if (sample_valid) begin
      case (r_state)
        ST_SETTLE: if (r_set_cnt == C_SET_LAST) begin
          w_settle_done = 1'b1;
          w_state_nxt   = ST_SEEK_MAX;
        end
        ST_SEEK_MAX: if (w_samp_ext + C_HYST <= {1'b0, r_max}) begin
          w_peak      = 1'b1;
          w_state_nxt = ST_SEEK_MIN;
        end
        ST_SEEK_MIN: if (w_samp_ext >= {1'b0, r_min} + C_HYST) begin
          w_trough    = 1'b1;
          w_state_nxt = ST_SEEK_MAX;
        end
        default: w_state_nxt = ST_SETTLE;
      endcase
    end
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      r_set_cnt <= '0;
      r_max     <= '0;
      r_min     <= '0;
      r_trough  <= '0;
      r_cnt     <= '0;
      r_first   <= 1'b1;
      r_timeout <= 1'b0;
      r_bv      <= 1'b0;
      r_bp      <= '0;
      r_ba      <= '0;
    end else begin
      r_bv <= 1'b0;
      if (sample_valid) begin
        case (r_state)
          ST_SETTLE: begin
            r_set_cnt <= w_settle_done ? '0 : r_set_cnt + 1'b1;
            if (w_settle_done) begin
              r_max   <= In_IR_Filtered;
              r_first <= 1'b1;
              r_cnt   <= '0;
            end
          end
          ST_SEEK_MAX: begin
            if (In_IR_Filtered > r_max) r_max <= In_IR_Filtered;
            if (w_peak)                 r_min <= In_IR_Filtered;
          end
          ST_SEEK_MIN: begin
            if (In_IR_Filtered < r_min) r_min <= In_IR_Filtered;
            if (w_trough) begin
              r_trough <= r_min;
              r_max    <= In_IR_Filtered;
            end
          end
          default: ;
        endcase

        if (r_state != ST_SETTLE) begin
          if (w_peak) begin
            if (r_first) begin
              r_cnt     <= '0;
              r_first   <= 1'b0;
              r_timeout <= 1'b0;
            end else if (w_cnt_inc < C_MINP) begin
              r_cnt <= w_cnt_inc;
            end else begin
              r_bv  <= 1'b1;
              r_bp  <= w_cnt_inc;
              r_ba  <= r_max - r_trough;
              r_cnt <= '0;
            end
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == C_MAXP) begin
              r_timeout <= 1'b1;
              r_first   <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign timeout = r_timeout;

`ifdef IR_PEAK_AVG_EN
  logic w_to_fire;
  assign w_to_fire = sample_valid && (r_state != ST_SETTLE) && !w_peak && (w_cnt_inc == C_MAXP);

  ir_period_avg #(
    .DATA_W   (DATA_W),
    .PERIOD_W (PERIOD_W)
  ) u_avg (
    .clk      (CLK_Filter),
    .rst_n    (rst_n),
    .i_clear  (w_to_fire),
    .i_valid  (r_bv),
    .i_period (r_bp),
    .i_amp    (r_ba),
    .o_valid  (beat_valid),
    .o_period (beat_period),
    .o_amp    (beat_amp)
  );
`else
  assign beat_valid  = r_bv;
  assign beat_period = r_bp;
  assign beat_amp    = r_ba;
`endif

endmodule

`default_nettype wire

// File: doc/ir_peak_detector.md
# ir_peak_detector

Consumes the 20-bit filtered IR sample stream produced by the FIR stage on CLK_Filter and extracts pulse beats. It tracks maxima and minima with hysteresis, measures the peak-to-peak interval in valid samples, and reports beat period and peak-to-trough amplitude with a one-cycle valid strobe. It sits directly downstream of the IR FIR filter and feeds the heart-rate/SpO2 computation.

## Interface
- DATA_W, 20, filtered sample width
- PERIOD_W, 12, period counter width
- SETTLE, 21, valid samples discarded after reset/timeout recovery (FIR fill)
- HYST, 256, hysteresis in LSBs for peak/trough declaration
- MIN_PERIOD, 20, shortest accepted period (samples)
- MAX_PERIOD, 4000, period at which timeout fires (≤ 2^PERIOD_W−1)

Ports:
- CLK_Filter  in  1  filter clock
- rst_n  in  1  reset, asynchronous, active-low
- sample_valid  in  1  In_IR_Filtered valid this cycle
- In_IR_Filtered  in  DATA_W  unsigned filtered sample
- beat_valid  out  1  one-cycle strobe, new beat reported
- beat_period  out  PERIOD_W  samples between accepted peaks
- beat_amp  out  DATA_W  peak minus preceding trough
- timeout  out  1  level, no accepted peak for MAX_PERIOD samples

## Operation
- All logic advances only on cycles with sample_valid=1; otherwise full state holds and beat_valid=0.
- States: SETTLE → SEEK_MAX ⇄ SEEK_MIN.
- SETTLE: count SETTLE valid samples, ignore data; on last one load max=sample, enter SEEK_MAX, first_peak=1.
- SEEK_MAX: if sample > max, max=sample. Peak declared when sample+HYST ≤ max (DATA_W+1-bit compare, no underflow); load min=sample, enter SEEK_MIN.
- SEEK_MIN: if sample < min, min=sample. Trough declared when sample ≥ min+HYST (DATA_W+1-bit); store trough=min, load max=sample, enter SEEK_MAX.
- Period counter: increments per valid sample, saturates at MAX_PERIOD.
- On peak declaration:
  - first_peak=1: no report; counter←0; first_peak←0; timeout←0.
  - counter < MIN_PERIOD: rejected as noise; no report; counter not reset; state transition still occurs.
  - otherwise: beat_valid=1, beat_period=counter, beat_amp=max−trough; counter←0.
- Counter reaching MAX_PERIOD: timeout←1, first_peak←1 (next peak re-arms, not reported). State machine keeps running.
- beat_period/beat_amp hold last reported values between strobes.

## Timing
- Reset values: beat_valid=0, beat_period=0, beat_amp=0, timeout=0; state SETTLE, counters 0.
- rst_n assertion mid-operation clears everything asynchronously; recovery always restarts SETTLE.
- beat_valid, beat_period, beat_amp registered: valid one cycle after the CLK_Filter edge sampling the triggering sample.
- timeout asserts the cycle after the counter reaches MAX_PERIOD; deasserts the cycle after the next peak declaration.
- Peak and timeout on the same sample: peak handling wins (counter reset, no timeout).

## Configuration
- IR_PEAK_AVG_EN defined: beat_period reports the mean of the last 4 accepted periods (sum >> 2, truncated). History is filled with the first accepted period after reset or timeout. Adds one cycle of latency to beat_valid/beat_period/beat_amp (all three stay aligned).
- Undefined: beat_period is the raw period of the current beat. Latency is as given under Timing.

## Structure
- Shared package ir_pkg: DATA_W, PERIOD_W defaults, state enum typedef (SETTLE, SEEK_MAX, SEEK_MIN), default HYST.
- Sub-module ir_period_avg (4-entry history, sum, shift, valid alignment) is instantiated only under IR_PEAK_AVG_EN.

## Test plan
- Reset, then 21 valid samples of 1000 → no beat_valid, timeout=0, all outputs 0.
- Triangle 10000↔20000, step 200, period 100 samples, continuous valid → first peak unreported; then beat_valid every 100 samples, beat_period=100, beat_amp=10000.
- Ripple ±100 around 15000 for 3000 samples → no beat_valid, no state change past SEEK_MAX.
- After one peak, hold flat 15000 → timeout=1 at sample 4000; resume triangle → first peak unreported and timeout cleared, second peak beat_period=100.
- Triangle with an extra peak 10 samples after a true peak → spike rejected; next true beat reports beat_period=100.
- Same triangle with sample_valid toggled 1/0 each cycle → beat_period=100, strobes 200 cycles apart. Assert rst_n mid-ramp → outputs 0 immediately, then SETTLE is re-run.
